// File: rtl/vcve2_vrf_ff_if.sv
// Vector register file access bundle: NumReadPorts read streamers plus one write streamer.
// Latency: none, wires only. Read ports: req/vaddr/gnt, then valid/ready beats with data/last.
// Backpressure: rd_ready_i stalls a read stream; wr_ready_o paces write beats; wr_done_o pulses at the end.
`timescale 1ns/1ps
interface vcve2_vrf_ff_if #(
    parameter int PortWidth    = 32,
    parameter int NumReadPorts = 2
);
    logic [NumReadPorts-1:0]                rd_req_i;
    logic [NumReadPorts-1:0][4:0]           rd_vaddr_i;
    logic [NumReadPorts-1:0]                rd_gnt_o;
    logic [NumReadPorts-1:0]                rd_valid_o;
    logic [NumReadPorts-1:0]                rd_ready_i;
    logic [NumReadPorts-1:0][PortWidth-1:0] rd_data_o;
    logic [NumReadPorts-1:0]                rd_last_o;

    logic                                   wr_req_i;
    logic [4:0]                             wr_vaddr_i;
    logic                                   wr_gnt_o;
    logic                                   wr_valid_i;
    logic                                   wr_ready_o;
    logic [PortWidth-1:0]                   wr_data_i;
    logic [PortWidth/8-1:0]                 wr_be_i;
    logic                                   wr_done_o;

    // Sequencer side drives requests and write beats.
    modport master (
        output rd_req_i, rd_vaddr_i, rd_ready_i,
        output wr_req_i, wr_vaddr_i, wr_valid_i, wr_data_i, wr_be_i,
        input  rd_gnt_o, rd_valid_o, rd_data_o, rd_last_o,
        input  wr_gnt_o, wr_ready_o, wr_done_o
    );

    // Register file side.
    modport slave (
        input  rd_req_i, rd_vaddr_i, rd_ready_i,
        input  wr_req_i, wr_vaddr_i, wr_valid_i, wr_data_i, wr_be_i,
        output rd_gnt_o, rd_valid_o, rd_data_o, rd_last_o,
        output wr_gnt_o, wr_ready_o, wr_done_o
    );
endinterface

// File: rtl/vcve2_vrf_ff.sv
// Flip-flop vector register file: NumVRegs x VLEN, streamed as PortWidth beats with per-register interlock.
// Latency: read beat 0 one cycle after grant; write ready one cycle after grant; wr_done one cycle after last beat.
// Backpressure: read beats hold while rd_ready_i is low; grants withheld on RAW/WAR hazards (read wins ties).
// Ports: clk_i, rst_ni (async active-low) and the slave side of vcve2_vrf_ff_if (read/write streamers).
`timescale 1ns/1ps
module vcve2_vrf_ff #(
    parameter int                   VLEN         = 128,
    parameter int                   PortWidth    = 32,
    parameter int                   NumVRegs     = 32,
    parameter int                   NumReadPorts = 2,
    parameter logic [PortWidth-1:0] WordZeroVal  = '0
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    vcve2_vrf_ff_if.slave  bus
);
    localparam int Beats    = VLEN / PortWidth;
    localparam int BeatW    = (Beats > 1) ? $clog2(Beats) : 1;
    localparam int NumBytes = PortWidth / 8;
    localparam logic [BeatW-1:0] FirstBeat = '0;
    localparam logic [BeatW-1:0] LastBeat  = BeatW'(Beats - 1);

    typedef enum logic { RdIdle, RdStream } rd_state_e;
    typedef enum logic { WrIdle, WrWrite  } wr_state_e;

    logic [PortWidth-1:0] mem [NumVRegs][Beats];

    rd_state_e            rd_state [NumReadPorts];
    logic [4:0]           rd_addr  [NumReadPorts];
    logic [BeatW-1:0]     rd_bcnt  [NumReadPorts];
    logic [PortWidth-1:0] rd_data  [NumReadPorts];

    wr_state_e            wr_state;
    logic [4:0]           wr_addr;
    logic [BeatW-1:0]     wr_bcnt;
    logic                 wr_done;

    logic [NumReadPorts-1:0] rd_gnt;
    logic                    wr_conflict;
    logic                    wr_gnt;
    logic                    wr_beat;

    // A read is refused while the write streamer owns its register; a write is refused
    // while any read streams its register or is being granted it this very cycle.
    always_comb begin
        wr_conflict = 1'b0;
        rd_gnt      = '0;
        for (int p = 0; p < NumReadPorts; p++) begin
            rd_gnt[p] = bus.rd_req_i[p] && (rd_state[p] == RdIdle) &&
                        !((wr_state == WrWrite) && (wr_addr == bus.rd_vaddr_i[p]));
            if (((rd_state[p] == RdStream) && (rd_addr[p] == bus.wr_vaddr_i)) ||
                (rd_gnt[p] && (bus.rd_vaddr_i[p] == bus.wr_vaddr_i))) begin
                wr_conflict = 1'b1;
            end
        end
        wr_gnt = bus.wr_req_i && (wr_state == WrIdle) && !wr_conflict;
    end

    assign wr_beat = (wr_state == WrWrite) && bus.wr_valid_i;

    // Read streamers. The register cannot change under a stream, so each beat is
    // fetched straight from storage when it is loaded.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int p = 0; p < NumReadPorts; p++) begin
                rd_state[p] <= RdIdle;
                rd_addr[p]  <= '0;
                rd_bcnt[p]  <= '0;
                rd_data[p]  <= WordZeroVal;
            end
        end else begin
            for (int p = 0; p < NumReadPorts; p++) begin
                case (rd_state[p])
                    RdIdle: begin
                        if (rd_gnt[p]) begin
                            rd_state[p] <= RdStream;
                            rd_addr[p]  <= bus.rd_vaddr_i[p];
                            rd_bcnt[p]  <= FirstBeat;
                            rd_data[p]  <= mem[bus.rd_vaddr_i[p]][FirstBeat];
                        end
                    end
                    RdStream: begin
                        if (bus.rd_ready_i[p]) begin
                            if (rd_bcnt[p] == LastBeat) begin
                                rd_state[p] <= RdIdle;
                            end else begin
                                rd_bcnt[p] <= rd_bcnt[p] + BeatW'(1);
                                rd_data[p] <= mem[rd_addr[p]][rd_bcnt[p] + BeatW'(1)];
                            end
                        end
                    end
                    default: rd_state[p] <= RdIdle;
                endcase
            end
        end
    end

    // Write streamer control.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_state <= WrIdle;
            wr_addr  <= '0;
            wr_bcnt  <= '0;
            wr_done  <= 1'b0;
        end else begin
            wr_done <= wr_beat && (wr_bcnt == LastBeat);
            case (wr_state)
                WrIdle: begin
                    if (wr_gnt) begin
                        wr_state <= WrWrite;
                        wr_addr  <= bus.wr_vaddr_i;
                        wr_bcnt  <= FirstBeat;
                    end
                end
                WrWrite: begin
                    if (bus.wr_valid_i) begin
                        if (wr_bcnt == LastBeat) begin
                            wr_state <= WrIdle;
                        end else begin
                            wr_bcnt <= wr_bcnt + BeatW'(1);
                        end
                    end
                end
                default: wr_state <= WrIdle;
            endcase
        end
    end

    // Storage. Reset wipes every register, which also discards a half-written one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NumVRegs; r++) begin
                for (int k = 0; k < Beats; k++) begin
                    mem[r][k] <= WordZeroVal;
                end
            end
        end else if (wr_beat) begin
            for (int by = 0; by < NumBytes; by++) begin
                if (bus.wr_be_i[by]) begin
                    mem[wr_addr][wr_bcnt][by*8 +: 8] <= bus.wr_data_i[by*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NumReadPorts; p++) begin
            bus.rd_valid_o[p] = (rd_state[p] == RdStream);
            bus.rd_last_o[p]  = (rd_state[p] == RdStream) && (rd_bcnt[p] == LastBeat);
            bus.rd_data_o[p]  = rd_data[p];
        end
    end

    assign bus.rd_gnt_o   = rd_gnt;
    assign bus.wr_gnt_o   = wr_gnt;
    assign bus.wr_ready_o = (wr_state == WrWrite);
    assign bus.wr_done_o  = wr_done;

    for (genvar p = 0; p < NumReadPorts; p++) begin : g_rd_addr_chk
        assert property (@(posedge clk_i) disable iff (!rst_ni)
            bus.rd_req_i[p] |-> (6'(bus.rd_vaddr_i[p]) < 6'(NumVRegs)));
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.wr_req_i |-> (6'(bus.wr_vaddr_i) < 6'(NumVRegs)));
endmodule

// File: tb/tb_vcve2_vrf_ff.sv
`timescale 1ns/1ps
module tb_vcve2_vrf_ff;
    localparam int VLEN  = 128;
    localparam int PW    = 32;
    localparam int NV    = 32;
    localparam int NRP   = 2;
    localparam int BEATS = VLEN / PW;
    localparam int NB    = PW / 8;
    localparam logic [PW-1:0] ZV = 32'h5A5A_00FF;

    typedef struct packed {
        logic [PW-1:0] data;
        logic          last;
    } beat_t;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    vcve2_vrf_ff_if #(.PortWidth(PW), .NumReadPorts(NRP)) bus ();

    vcve2_vrf_ff #(
        .VLEN(VLEN), .PortWidth(PW), .NumVRegs(NV), .NumReadPorts(NRP), .WordZeroVal(ZV)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: register contents and stream ownership ----------------
    logic [PW-1:0] mm [NV][BEATS];
    logic          m_rd_busy [NRP];
    int            m_rd_left [NRP];
    logic [4:0]    m_rd_addr [NRP];
    logic          m_wr_busy;
    logic [4:0]    m_wr_addr;
    int            m_wr_cnt;
    logic          m_done_next;
    beat_t         q0[$];
    beat_t         q1[$];

    task automatic model_reset();
        for (int r = 0; r < NV; r++)
            for (int k = 0; k < BEATS; k++) mm[r][k] = ZV;
        for (int p = 0; p < NRP; p++) begin
            m_rd_busy[p] = 1'b0; m_rd_left[p] = 0; m_rd_addr[p] = '0;
        end
        m_wr_busy = 1'b0; m_wr_addr = '0; m_wr_cnt = 0; m_done_next = 1'b0;
        q0.delete(); q1.delete();
    endtask

    task automatic model_step();
        logic eg [NRP];
        logic rb [NRP];
        logic wb, conf, ewg, last_w;
        beat_t e;
        wb = m_wr_busy;
        for (int p = 0; p < NRP; p++) rb[p] = m_rd_busy[p];
        for (int p = 0; p < NRP; p++)
            check($sformatf("rd_valid[%0d]", p), 64'(bus.rd_valid_o[p]), 64'(rb[p]));
        check("wr_ready", 64'(bus.wr_ready_o), 64'(wb));
        check("wr_done", 64'(bus.wr_done_o), 64'(m_done_next));
        conf = 1'b0;
        for (int p = 0; p < NRP; p++) begin
            eg[p] = bus.rd_req_i[p] && !rb[p] && !(wb && (m_wr_addr == bus.rd_vaddr_i[p]));
            if (bus.rd_req_i[p])
                check($sformatf("rd_gnt[%0d]", p), 64'(bus.rd_gnt_o[p]), 64'(eg[p]));
            if ((rb[p] && (m_rd_addr[p] == bus.wr_vaddr_i)) ||
                (eg[p] && (bus.rd_vaddr_i[p] == bus.wr_vaddr_i))) conf = 1'b1;
        end
        ewg = bus.wr_req_i && !wb && !conf;
        if (bus.wr_req_i) check("wr_gnt", 64'(bus.wr_gnt_o), 64'(ewg));
        for (int p = 0; p < NRP; p++) begin
            if (rb[p] && bus.rd_ready_i[p]) begin
                m_rd_left[p]--;
                if (m_rd_left[p] == 0) m_rd_busy[p] = 1'b0;
            end
        end
        last_w = 1'b0;
        if (wb && bus.wr_valid_i) begin
            for (int b = 0; b < NB; b++)
                if (bus.wr_be_i[b]) mm[m_wr_addr][m_wr_cnt][b*8 +: 8] = bus.wr_data_i[b*8 +: 8];
            m_wr_cnt++;
            if (m_wr_cnt == BEATS) begin m_wr_busy = 1'b0; last_w = 1'b1; end
        end
        m_done_next = last_w;
        for (int p = 0; p < NRP; p++) begin
            if (eg[p]) begin
                m_rd_busy[p] = 1'b1;
                m_rd_left[p] = BEATS;
                m_rd_addr[p] = bus.rd_vaddr_i[p];
                for (int k = 0; k < BEATS; k++) begin
                    e.data = mm[bus.rd_vaddr_i[p]][k];
                    e.last = (k == BEATS - 1);
                    if (p == 0) q0.push_back(e); else q1.push_back(e);
                end
            end
        end
        if (ewg) begin
            m_wr_busy = 1'b1; m_wr_addr = bus.wr_vaddr_i; m_wr_cnt = 0;
        end
    endtask

    always @(negedge clk_i) begin
        if (!rst_ni) model_reset();
        else         model_step();
    end

    // ---------------- monitor: pops expected beats on every read handshake ----------------
    logic          hold_pend [NRP];
    logic [PW-1:0] hold_dat  [NRP];

    task automatic mon_step();
        beat_t e;
        logic  have;
        for (int p = 0; p < NRP; p++) begin
            if (bus.rd_valid_o[p] && hold_pend[p])
                check($sformatf("rd_hold[%0d]", p), 64'(bus.rd_data_o[p]), 64'(hold_dat[p]));
            hold_pend[p] = 1'b0;
            if (bus.rd_valid_o[p] && bus.rd_ready_i[p]) begin
                have = 1'b0;
                if (p == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                if (p == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                if (!have) begin
                    checks++; failures++;
                    $display("FAIL rd_unexpected_beat[%0d]: got %0h, expected no beat", p, bus.rd_data_o[p]);
                end else begin
                    check($sformatf("rd_data[%0d]", p), 64'(bus.rd_data_o[p]), 64'(e.data));
                    check($sformatf("rd_last[%0d]", p), 64'(bus.rd_last_o[p]), 64'(e.last));
                end
            end else if (bus.rd_valid_o[p]) begin
                hold_pend[p] = 1'b1;
                hold_dat[p]  = bus.rd_data_o[p];
            end
        end
    endtask

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            for (int p = 0; p < NRP; p++) hold_pend[p] = 1'b0;
        end else begin
            mon_step();
        end
    end

    // ---------------- read-ready drivers: 0 = always ready, 1 = toggle, 2 = random ----------------
    int rdy_mode [NRP];

    always @(posedge clk_i) begin
        #1;
        for (int p = 0; p < NRP; p++) begin
            case (rdy_mode[p])
                0:       bus.rd_ready_i[p] = 1'b1;
                1:       bus.rd_ready_i[p] = ~bus.rd_ready_i[p];
                default: bus.rd_ready_i[p] = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic do_read(input int p, input logic [4:0] a);
        int n;
        n = 0;
        @(posedge clk_i); #1;
        bus.rd_req_i[p]   = 1'b1;
        bus.rd_vaddr_i[p] = a;
        do begin @(negedge clk_i); n++; end while (!bus.rd_gnt_o[p] && n < 300);
        if (!bus.rd_gnt_o[p]) begin
            checks++; failures++;
            $display("FAIL rd_gnt_timeout[%0d]: got no grant, expected one within 300 cycles", p);
        end
        @(posedge clk_i); #1;
        bus.rd_req_i[p] = 1'b0;
    endtask

    task automatic check_reset_outputs();
        for (int p = 0; p < NRP; p++) begin
            check($sformatf("rst_rd_valid[%0d]", p), 64'(bus.rd_valid_o[p]), 64'(0));
            check($sformatf("rst_rd_last[%0d]", p), 64'(bus.rd_last_o[p]), 64'(0));
            check($sformatf("rst_rd_data[%0d]", p), 64'(bus.rd_data_o[p]), 64'(ZV));
        end
        check("rst_wr_ready", 64'(bus.wr_ready_o), 64'(0));
        check("rst_wr_done", 64'(bus.wr_done_o), 64'(0));
    endtask

    // abort_at >= 0 asserts reset partway through that beat.
    task automatic do_write(input logic [4:0] a, input logic [BEATS-1:0][PW-1:0] d,
                            input logic [BEATS-1:0][NB-1:0] be, input int abort_at);
        int n;
        n = 0;
        @(posedge clk_i); #1;
        bus.wr_req_i   = 1'b1;
        bus.wr_vaddr_i = a;
        do begin @(negedge clk_i); n++; end while (!bus.wr_gnt_o && n < 300);
        if (!bus.wr_gnt_o) begin
            checks++; failures++;
            $display("FAIL wr_gnt_timeout: got no grant, expected one within 300 cycles");
        end
        @(posedge clk_i); #1;
        bus.wr_req_i = 1'b0;
        for (int k = 0; k < BEATS; k++) begin
            bus.wr_valid_i = 1'b1;
            bus.wr_data_i  = d[k];
            bus.wr_be_i    = be[k];
            if (k == abort_at) begin
                #2 rst_ni = 1'b0;
                @(negedge clk_i);
                check_reset_outputs();
                bus.wr_valid_i = 1'b0;
                return;
            end
            n = 0;
            do begin @(negedge clk_i); n++; end while (!bus.wr_ready_o && n < 50);
            if (!bus.wr_ready_o) begin
                checks++; failures++;
                $display("FAIL wr_ready_timeout: got wr_ready_o=0, expected 1 within 50 cycles");
            end
            @(posedge clk_i); #1;
        end
        bus.wr_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int  n;
        logic busy;
        n = 0;
        do begin
            @(negedge clk_i); n++;
            busy = m_wr_busy || m_done_next;
            for (int p = 0; p < NRP; p++) busy = busy || m_rd_busy[p];
        end while (busy && n < 1000);
        if (busy) begin
            checks++; failures++;
            $display("FAIL idle_timeout: got streams still busy, expected idle within 1000 cycles");
        end
    endtask

    // ---------------- test sequence ----------------
    logic [BEATS-1:0][PW-1:0] wd;
    logic [BEATS-1:0][NB-1:0] wbe;
    logic [4:0]               ra0, ra1, wa;

    initial begin
        bus.rd_req_i   = '0;
        bus.rd_vaddr_i = '0;
        bus.rd_ready_i = '0;
        bus.wr_req_i   = 1'b0;
        bus.wr_vaddr_i = '0;
        bus.wr_valid_i = 1'b0;
        bus.wr_data_i  = '0;
        bus.wr_be_i    = '0;
        for (int p = 0; p < NRP; p++) rdy_mode[p] = 0;

        repeat (2) @(negedge clk_i);
        check_reset_outputs();
        @(posedge clk_i); #1 rst_ni = 1'b1;

        // Fresh register reads back the reset word on every beat.
        do_read(0, 5'd5);
        wait_idle();

        // Full write then read back.
        wd  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        wbe = {4'hF, 4'hF, 4'hF, 4'hF};
        do_write(5'd3, wd, wbe, -1);
        wait_idle();
        do_read(0, 5'd3);
        wait_idle();

        // Low-byte-only rewrite.
        wd  = {4{32'hAAAAAAAA}};
        wbe = {4'h1, 4'h1, 4'h1, 4'h1};
        do_write(5'd3, wd, wbe, -1);
        wait_idle();
        do_read(0, 5'd3);
        wait_idle();

        // RAW: port 1 asks for v3 while it is being written.
        wd  = {32'hDEAD0003, 32'hBEEF0002, 32'hCAFE0001, 32'hF00D0000};
        wbe = {4'hF, 4'h3, 4'hC, 4'h0};
        fork
            do_write(5'd3, wd, wbe, -1);
            begin repeat (2) @(posedge clk_i); do_read(1, 5'd3); end
        join
        wait_idle();

        // WAR with same-cycle requests: read wins, stalled beats must hold.
        rdy_mode[0] = 1;
        wd  = {32'h77777777, 32'h66666666, 32'h55555555, 32'h12345678};
        wbe = {4'hF, 4'hF, 4'hF, 4'hF};
        fork
            do_read(0, 5'd7);
            do_write(5'd7, wd, wbe, -1);
        join
        wait_idle();
        do_read(1, 5'd7);
        wait_idle();

        // Reset during a write (and a stalled read of another register).
        do_write(5'd9, {32'h9, 32'h8, 32'h7, 32'h6}, {4'hF, 4'hF, 4'hF, 4'hF}, -1);
        wait_idle();
        do_read(0, 5'd9);
        do_write(5'd4, {32'h4, 32'h3, 32'h2, 32'h1}, {4'hF, 4'hF, 4'hF, 4'hF}, 2);
        @(posedge clk_i); #1 rst_ni = 1'b1;
        rdy_mode[0] = 0;
        do_read(0, 5'd4);
        wait_idle();
        do_read(1, 5'd9);
        wait_idle();

        // Random traffic over a few registers to provoke hazards.
        rdy_mode[0] = 2;
        rdy_mode[1] = 2;
        for (int it = 0; it < 40; it++) begin
            ra0 = 5'($urandom_range(0, 3));
            ra1 = 5'($urandom_range(0, 3));
            wa  = 5'($urandom_range(0, 3));
            for (int k = 0; k < BEATS; k++) begin
                wd[k]  = $urandom;
                wbe[k] = 4'($urandom_range(0, 15));
            end
            fork
                do_read(0, ra0);
                do_read(1, ra1);
                do_write(wa, wd, wbe, -1);
            join
        end
        wait_idle();
        check("q0_drained", 64'(q0.size()), 64'(0));
        check("q1_drained", 64'(q1.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got simulation still running, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "global timeout");
    end
endmodule
